// File: rtl/sort_stream_host_pkg.sv
// Shared types for the sort host front end: row geometry, data types and host FSM states.
`ifndef SORT_STREAM_HOST_ADFF
// Async-reset flop: q takes rv while rst is high, otherwise d on each rising clock.
`define SORT_STREAM_HOST_ADFF(q, d, clk, rst, rv) \
   always_ff @(posedge clk or posedge rst) if (rst) q <= rv; else q <= d;
`endif

package sort_stream_host_pkg;

   localparam int unsigned NUM_ROWS = 8;

   typedef logic [$clog2(NUM_ROWS)-1:0] t_addr;
   typedef logic [15:0]                 t_data;

   typedef enum logic [1:0] {LOAD, KICK, SORT, UNLOAD} t_host_fsm;

endpackage

// File: rtl/sort_stream_host_if.sv
// Bundle of the host streams, sorter handshake/memory port and the row-memory port.
interface sort_stream_host_if;
   import sort_stream_host_pkg::*;

   logic  in_valid;
   logic  in_ready;
   t_data in_data;
   logic  in_last;

   logic  out_valid;
   logic  out_ready;
   t_data out_data;
   logic  out_last;

   logic  sort_start;
   logic  sort_done;
   t_addr srt_rd_addr;
   t_data srt_rd_data;
   logic  srt_wr_en;
   t_addr srt_wr_addr;
   t_data srt_wr_data;

   t_addr mem_rd_addr;
   t_data mem_rd_data;
   logic  mem_wr_en;
   t_addr mem_wr_addr;
   t_data mem_wr_data;

   logic  busy;
   logic  frame_err;

   // Host block view.
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      input  sort_done, srt_rd_addr, srt_wr_en, srt_wr_addr, srt_wr_data,
      input  mem_rd_data,
      output in_ready, out_valid, out_data, out_last,
      output sort_start, srt_rd_data,
      output mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
      output busy, frame_err
   );

   // Environment view: stream source/sink, sorter and row memory.
   modport master (
      output in_valid, in_data, in_last, out_ready,
      output sort_done, srt_rd_addr, srt_wr_en, srt_wr_addr, srt_wr_data,
      output mem_rd_data,
      input  in_ready, out_valid, out_data, out_last,
      input  sort_start, srt_rd_data,
      input  mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
      input  busy, frame_err
   );

endinterface

// File: rtl/sort_stream_host_mem_port_mux.sv
// Row-memory port select: the sorter owns the port while sorting, the host otherwise.
module sort_stream_host_mem_port_mux
   import sort_stream_host_pkg::*;
(
   input  logic  sel_sort,
   input  t_addr host_rd_addr,
   input  logic  host_wr_en,
   input  t_addr host_wr_addr,
   input  t_data host_wr_data,
   input  t_addr srt_rd_addr,
   output t_data srt_rd_data,
   input  logic  srt_wr_en,
   input  t_addr srt_wr_addr,
   input  t_data srt_wr_data,
   output t_addr mem_rd_addr,
   input  t_data mem_rd_data,
   output logic  mem_wr_en,
   output t_addr mem_wr_addr,
   output t_data mem_wr_data
);

   // Pure pass-through; the sorter sees zero read data and cannot write when not selected.
   always_comb begin
      if (sel_sort) begin
         mem_rd_addr = srt_rd_addr;
         mem_wr_en   = srt_wr_en;
         mem_wr_addr = srt_wr_addr;
         mem_wr_data = srt_wr_data;
         srt_rd_data = mem_rd_data;
      end else begin
         mem_rd_addr = host_rd_addr;
         mem_wr_en   = host_wr_en;
         mem_wr_addr = host_wr_addr;
         mem_wr_data = host_wr_data;
         srt_rd_data = '0;
      end
   end

endmodule

// File: rtl/sort_stream_host.sv
// Host front end for the selection sorter: load a frame, kick the sorter, stream the result out.
module sort_stream_host
   import sort_stream_host_pkg::*;
#(
   parameter int unsigned N_ROWS = NUM_ROWS
) (
   input logic            clk,
   input logic            rst,
   sort_stream_host_if.slave bus
);

   localparam t_addr LAST_PTR = t_addr'(N_ROWS - 1);

   t_host_fsm state;
   t_addr     ptr;
   logic      frame_err_q;
   logic      frame_err_d;

   logic in_beat;
   logic out_beat;
   logic at_last;

   assign at_last  = (ptr == LAST_PTR);
   assign in_beat  = (state == LOAD) && bus.in_valid;
   assign out_beat = (state == UNLOAD) && bus.out_ready;

   // Frame sequencing: row pointer and phase advance on stream handshakes and sorter done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= LOAD;
         ptr   <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (in_beat) begin
                  if (at_last) begin
                     ptr   <= '0;
                     state <= KICK;
                  end else begin
                     ptr <= ptr + t_addr'(1);
                  end
               end
            end
            KICK: state <= SORT;
            SORT: begin
               if (bus.sort_done) begin
                  ptr   <= '0;
                  state <= UNLOAD;
               end
            end
            UNLOAD: begin
               if (out_beat) begin
                  if (at_last) begin
                     ptr   <= '0;
                     state <= LOAD;
                  end else begin
                     ptr <= ptr + t_addr'(1);
                  end
               end
            end
            default: begin
               ptr   <= '0;
               state <= LOAD;
            end
         endcase
      end
   end

   // Framing error: in_last must coincide exactly with the final row; a mismatch sticks until rst.
   always_comb begin
      frame_err_d = frame_err_q | (in_beat & (bus.in_last != at_last));
   end

   `SORT_STREAM_HOST_ADFF(frame_err_q, frame_err_d, clk, rst, 1'b0)

   // Stream and status outputs decoded from the registered phase and pointer.
   always_comb begin
      bus.in_ready   = (state == LOAD);
      bus.sort_start = (state == KICK);
      bus.out_valid  = (state == UNLOAD);
      bus.out_last   = (state == UNLOAD) && at_last;
      bus.out_data   = (state == UNLOAD) ? bus.mem_rd_data : '0;
      bus.busy       = !((state == LOAD) && (ptr == '0));
      bus.frame_err  = frame_err_q;
   end

   t_addr host_rd_addr;
   t_addr host_wr_addr;
   t_data host_wr_data;

   assign host_rd_addr = (state == UNLOAD) ? ptr : '0;
   assign host_wr_addr = in_beat ? ptr : '0;
   assign host_wr_data = in_beat ? bus.in_data : '0;

   sort_stream_host_mem_port_mux u_mux (
      .sel_sort     (state == SORT),
      .host_rd_addr (host_rd_addr),
      .host_wr_en   (in_beat),
      .host_wr_addr (host_wr_addr),
      .host_wr_data (host_wr_data),
      .srt_rd_addr  (bus.srt_rd_addr),
      .srt_rd_data  (bus.srt_rd_data),
      .srt_wr_en    (bus.srt_wr_en),
      .srt_wr_addr  (bus.srt_wr_addr),
      .srt_wr_data  (bus.srt_wr_data),
      .mem_rd_addr  (bus.mem_rd_addr),
      .mem_rd_data  (bus.mem_rd_data),
      .mem_wr_en    (bus.mem_wr_en),
      .mem_wr_addr  (bus.mem_wr_addr),
      .mem_wr_data  (bus.mem_wr_data)
   );

endmodule

// File: tb/tb_sort_stream_host.sv
// Bench for sort_stream_host with a behavioural row memory and sorter peer.
module tb_sort_stream_host;
   import sort_stream_host_pkg::*;

   localparam int N = 4;
   typedef logic [N-1:0][15:0] frame_t;

   typedef struct packed {
      frame_t     v;
      frame_t     e;
      logic [2:0] lb;     // beat carrying in_last; 7 = none
      logic [1:0] rmode;  // 0 always ready, 1 pattern 1,0,0,1, 2 random
      logic [1:0] abort;  // 0 none, 1 reset in SORT, 2 reset in UNLOAD after 2 beats
      logic       hold;   // keep in_valid high through SORT/UNLOAD
      logic       eerr;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic spur_done = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   sort_stream_host_if bus ();

   sort_stream_host #(.N_ROWS(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Row memory: combinational read, synchronous write.
   logic [15:0] mem [8];
   assign bus.mem_rd_data = mem[bus.mem_rd_addr];
   always @(posedge clk) if (bus.mem_wr_en) mem[bus.mem_wr_addr] <= bus.mem_wr_data;

   function automatic frame_t sorted_of(input frame_t a);
      int     q[$];
      frame_t r;
      for (int i = 0; i < N; i++) q.push_back(int'(a[i]));
      q.sort();
      for (int i = 0; i < N; i++) r[i] = 16'(q[i]);
      return r;
   endfunction

   // Sorter peer: reads every row through the host mux, writes them back ascending, pulses done.
   int     sph;
   int     scnt;
   frame_t rbuf;
   frame_t rsorted;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sph  <= 0;
         scnt <= 0;
      end else begin
         case (sph)
            0: if (bus.sort_start) begin sph <= 1; scnt <= 0; end
            1: begin
               rbuf[scnt] <= bus.srt_rd_data;
               if (scnt == N - 1) begin sph <= 2; scnt <= 0; end else scnt <= scnt + 1;
            end
            2: if (scnt == N - 1) begin sph <= 3; scnt <= 0; end else scnt <= scnt + 1;
            default: sph <= 0;
         endcase
      end
   end

   always_comb begin
      rsorted         = sorted_of(rbuf);
      bus.srt_rd_addr = (sph == 1) ? t_addr'(scnt) : '0;
      bus.srt_wr_en   = (sph == 2);
      bus.srt_wr_addr = (sph == 2) ? t_addr'(scnt) : '0;
      bus.srt_wr_data = (sph == 2) ? rsorted[scnt] : '0;
      bus.sort_done   = (sph == 3) | spur_done;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_sort_start", bus.sort_start, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_frame_err", bus.frame_err, 0);
      chk("rst_mem_wr_en", bus.mem_wr_en, 0);
      chk("rst_mem_rd_addr", bus.mem_rd_addr, 0);
      chk("rst_srt_rd_data", bus.srt_rd_data, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_frame(input frame_t v, input int lb, input int rmode, input int abort,
                            input bit hold, input frame_t e, input bit eerr);
      bit done;
      int cyc;
      int k;
      int t;
      bit rdy;
      // load
      for (int i = 0; i < N; i++) begin
         if (rmode == 2) begin
            while ($urandom_range(0, 3) == 0) begin
               @(negedge clk);
               bus.in_valid = 1'b0;
               #1 chk("idle_wr_en", bus.mem_wr_en, 0);
            end
         end
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = v[i];
         bus.in_last  = (i == lb);
         #1;
         chk("load_in_ready", bus.in_ready, 1);
         chk("load_wr_en", bus.mem_wr_en, 1);
         chk("load_wr_addr", bus.mem_wr_addr, i);
         chk("load_wr_data", bus.mem_wr_data, v[i]);
      end
      @(negedge clk);
      bus.in_valid = hold;
      bus.in_last  = 1'b0;
      bus.in_data  = 16'hdead;
      #1;
      chk("kick_start", bus.sort_start, 1);
      chk("kick_in_ready", bus.in_ready, 0);
      chk("kick_busy", bus.busy, 1);
      chk("kick_wr_en", bus.mem_wr_en, 0);
      // sort
      done = 1'b0;
      cyc  = 0;
      while (!done && cyc < 50) begin
         @(negedge clk);
         #1;
         chk("sort_in_ready", bus.in_ready, 0);
         chk("sort_start_once", bus.sort_start, 0);
         chk("sort_out_valid", bus.out_valid, 0);
         chk("pass_rd_addr", bus.mem_rd_addr, bus.srt_rd_addr);
         chk("pass_rd_data", bus.srt_rd_data, mem[bus.srt_rd_addr]);
         chk("pass_wr_en", bus.mem_wr_en, bus.srt_wr_en);
         if (bus.srt_wr_en) chk("pass_wr_data", bus.mem_wr_data, bus.srt_wr_data);
         if (abort == 1 && cyc == 2) begin
            do_reset();
            return;
         end
         done = bus.sort_done;
         cyc++;
      end
      if (!done) begin
         chk("sort_timeout", 0, 1);
         return;
      end
      // unload
      k = 0;
      t = 0;
      cyc = 0;
      while (k < N && cyc < 100) begin
         @(negedge clk);
         if (rmode == 0) rdy = 1'b1;
         else if (rmode == 1) rdy = (t % 4 == 0) || (t % 4 == 3);
         else rdy = 1'($urandom_range(0, 1));
         t++;
         bus.out_ready = rdy;
         #1;
         chk("out_valid", bus.out_valid, 1);
         chk("out_data", bus.out_data, e[k]);
         chk("out_last", bus.out_last, (k == N - 1));
         chk("unload_in_ready", bus.in_ready, 0);
         chk("unload_wr_en", bus.mem_wr_en, 0);
         if (rdy) k++;
         if (abort == 2 && k == 2) begin
            @(negedge clk);
            do_reset();
            return;
         end
         cyc++;
      end
      if (k < N) begin
         chk("unload_timeout", k, N);
         return;
      end
      if (!hold) begin
         @(negedge clk);
         bus.out_ready = 1'b0;
         bus.in_valid  = 1'b0;
         #1;
         chk("end_in_ready", bus.in_ready, 1);
         chk("end_out_valid", bus.out_valid, 0);
         chk("end_busy", bus.busy, 0);
         chk("end_frame_err", bus.frame_err, eerr);
      end
   endtask

   vec_t tbl[$];

   task automatic add_vec(input logic [15:0] a0, a1, a2, a3, input int lb, rmode, abort,
                          input bit hold, input logic [15:0] e0, e1, e2, e3, input bit eerr);
      vec_t r;
      r.v[0] = a0; r.v[1] = a1; r.v[2] = a2; r.v[3] = a3;
      r.e[0] = e0; r.e[1] = e1; r.e[2] = e2; r.e[3] = e3;
      r.lb = 3'(lb);
      r.rmode = 2'(rmode);
      r.abort = 2'(abort);
      r.hold = hold;
      r.eerr = eerr;
      tbl.push_back(r);
   endtask

   initial begin
      frame_t rv;
      int     rlb;
      bit     sticky;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;

      add_vec(7, 3, 9, 1, 3, 0, 0, 0, 1, 3, 7, 9, 0);
      add_vec(7, 3, 9, 1, 3, 1, 0, 0, 1, 3, 7, 9, 0);
      add_vec(16'hFFFF, 0, 16'h8000, 1, 3, 0, 0, 1, 0, 1, 16'h8000, 16'hFFFF, 0);
      add_vec(2, 2, 2, 2, 3, 0, 0, 0, 2, 2, 2, 2, 0);
      add_vec(5, 5, 2, 8, 1, 2, 0, 0, 2, 5, 5, 8, 1);
      add_vec(7, 3, 9, 1, 3, 0, 1, 0, 1, 3, 7, 9, 0);
      add_vec(8, 6, 4, 2, 3, 0, 2, 0, 2, 4, 6, 8, 0);
      add_vec(4, 3, 2, 1, 3, 0, 0, 0, 1, 2, 3, 4, 0);
      add_vec(6, 1, 4, 0, 7, 0, 0, 0, 0, 1, 4, 6, 1);

      @(negedge clk);
      do_reset();

      foreach (tbl[i])
         run_frame(tbl[i].v, int'(tbl[i].lb), int'(tbl[i].rmode), int'(tbl[i].abort),
                   tbl[i].hold, tbl[i].e, tbl[i].eerr);

      // Spurious done while idle in LOAD must not start an unload.
      @(negedge clk);
      spur_done = 1'b1;
      #1 chk("spur_out_valid", bus.out_valid, 0);
      @(negedge clk);
      spur_done = 1'b0;
      #1;
      chk("spur_out_valid2", bus.out_valid, 0);
      chk("spur_in_ready", bus.in_ready, 1);
      chk("spur_busy", bus.busy, 0);

      do_reset();

      // Randomized frames against the sorted-frame reference.
      sticky = 1'b0;
      for (int r = 0; r < 15; r++) begin
         for (int i = 0; i < N; i++) rv[i] = 16'($urandom);
         rlb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, N)) : N - 1;
         if (rlb == N) rlb = 7;
         for (int i = 0; i < N; i++) if ((i == rlb) != (i == N - 1)) sticky = 1'b1;
         run_frame(rv, rlb, 2, 0, 1'($urandom_range(0, 1)), sorted_of(rv), sticky);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
